// File: rtl/ddr5_cmd_responder.sv
// ddr5_cmd_responder: two-beat DDR5 command responder with bank table, tRCD/tRP waits and read-return pipe
module ddr5_cmd_responder #(
    parameter int RD_LAT = 4,
    parameter int T_RCD  = 3,
    parameter int T_RP   = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [2:0]  i_cmd_op,
    input  logic [2:0]  i_cmd_bg,
    input  logic [1:0]  i_cmd_ba,
    input  logic [15:0] i_cmd_addr,
    output logic        o_rd_valid,
    output logic [2:0]  o_rd_bg,
    output logic [1:0]  o_rd_ba,
    output logic [15:0] o_rd_row,
    output logic [5:0]  o_rd_col,
    output logic        o_wr_ack,
    output logic        o_err,
    output logic [2:0]  o_err_code,
    output logic [5:0]  o_open_cnt
);
    localparam logic [2:0] OP_NOP = 3'd0, OP_ACT1 = 3'd2, OP_RD1 = 3'd4, OP_WR1 = 3'd6, OP_PRE = 3'd7;
    typedef enum logic [1:0] {IDLE, HALF, WAIT} state_t;
    state_t      r_state, w_next;
    logic        r_ready, r_wr_ack, r_err;
    logic [3:0]  r_timer;
    logic [31:0] r_open;
    logic [15:0] r_row [32];
    logic [2:0]  r_lop, r_code;
    logic [4:0]  r_lidx;
    logic [15:0] r_laddr;
    logic [5:0]  r_cnt;
    logic        r_pv [RD_LAT];
    logic [26:0] r_pd [RD_LAT];
    logic        w_hs, w_match, w_latch, w_act, w_pre, w_rd, w_wr, w_err;
    logic [2:0]  w_code;
    logic [4:0]  w_idx;

    assign w_hs    = i_cmd_valid & r_ready;
    assign w_idx   = {i_cmd_bg, i_cmd_ba};
    assign w_match = (i_cmd_op == r_lop + 3'd1) && (w_idx == r_lidx);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        w_act   = 1'b0;
        w_pre   = 1'b0;
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        w_err   = 1'b0;
        w_code  = 3'd0;
        case (r_state)
            IDLE: begin
                if (w_hs && i_cmd_op[0] && i_cmd_op != OP_PRE) begin
                    w_latch = 1'b1;
                    w_next  = HALF;
                end else if (w_hs && i_cmd_op == OP_PRE) begin
                    w_pre  = 1'b1;
                    w_next = WAIT;
                end else if (w_hs && i_cmd_op != OP_NOP) begin
                    w_err  = 1'b1;
                    w_code = 3'd1;
                end
            end
            HALF: begin
                // odd opcodes are first halves or PRE, all illegal while a half is pending
                if (w_hs && i_cmd_op != OP_NOP) begin
                    w_next = IDLE;
                    if (i_cmd_op[0]) begin
                        w_err  = 1'b1;
                        w_code = 3'd1;
                    end else if (!w_match) begin
                        w_err  = 1'b1;
                        w_code = 3'd2;
                    end else if (i_cmd_op == OP_ACT1) begin
                        w_err  = r_open[r_lidx];
                        w_code = r_open[r_lidx] ? 3'd3 : 3'd0;
                        w_act  = !r_open[r_lidx];
                        w_next = r_open[r_lidx] ? IDLE : WAIT;
                    end else if (r_open[r_lidx]) begin
                        w_rd = i_cmd_op == OP_RD1;
                        w_wr = i_cmd_op == OP_WR1;
                    end else begin
                        w_err  = 1'b1;
                        w_code = 3'd4;
                    end
                end
            end
            WAIT: w_next = r_timer <= 4'd1 ? IDLE : WAIT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ready  <= 1'b1;
            r_timer  <= '0;
            r_open   <= '0;
            r_lop    <= '0;
            r_lidx   <= '0;
            r_laddr  <= '0;
            r_cnt    <= '0;
            r_wr_ack <= 1'b0;
            r_err    <= 1'b0;
            r_code   <= '0;
        end else begin
            r_ready <= w_next != WAIT;
            if (w_latch) begin
                r_lop   <= i_cmd_op;
                r_lidx  <= w_idx;
                r_laddr <= i_cmd_addr;
            end
            if (w_act) begin
                r_open[r_lidx] <= 1'b1;
                r_timer        <= 4'(T_RCD);
                r_cnt          <= r_cnt + 6'd1;
            end else if (w_pre) begin
                r_open[w_idx] <= 1'b0;
                r_timer       <= 4'(T_RP);
                if (r_open[w_idx]) r_cnt <= r_cnt - 6'd1;
            end else if (r_state == WAIT) begin
                r_timer <= r_timer - 4'd1;
            end
            r_wr_ack <= w_wr;
            r_err    <= w_err;
            if (w_err) r_code <= w_code;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_act) r_row[r_lidx] <= r_laddr;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < RD_LAT; k++) begin
                r_pv[k] <= 1'b0;
                r_pd[k] <= '0;
            end
        end else begin
            r_pv[0] <= w_rd;
            r_pd[0] <= w_rd ? {r_lidx, r_row[r_lidx], r_laddr[5:0]} : '0;
            for (int k = 1; k < RD_LAT; k++) begin
                r_pv[k] <= r_pv[k-1];
                r_pd[k] <= r_pd[k-1];
            end
        end
    end

    assign o_cmd_ready = r_ready;
    assign o_rd_valid  = r_pv[RD_LAT-1];
    assign {o_rd_bg, o_rd_ba, o_rd_row, o_rd_col} = r_pd[RD_LAT-1];
    assign o_wr_ack    = r_wr_ack;
    assign o_err       = r_err;
    assign o_err_code  = r_code;
    assign o_open_cnt  = r_cnt;
endmodule

// File: tb/tb_ddr5_cmd_responder.sv
// tb_ddr5_cmd_responder: directed scenarios plus randomized traffic against a cycle-stamped command model
module tb_ddr5_cmd_responder;
    localparam int RD_LAT = 4, T_RCD = 3, T_RP = 2;
    logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0;
    logic [2:0]  op = '0, bg = '0;
    logic [1:0]  ba = '0;
    logic [15:0] addr = '0;
    logic        o_cmd_ready, o_rd_valid, o_wr_ack, o_err;
    logic [2:0]  o_rd_bg, o_err_code;
    logic [1:0]  o_rd_ba;
    logic [15:0] o_rd_row;
    logic [5:0]  o_rd_col, o_open_cnt;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    ddr5_cmd_responder #(.RD_LAT(RD_LAT), .T_RCD(T_RCD), .T_RP(T_RP)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_op(op), .i_cmd_bg(bg), .i_cmd_ba(ba), .i_cmd_addr(addr),
        .o_rd_valid(o_rd_valid), .o_rd_bg(o_rd_bg), .o_rd_ba(o_rd_ba), .o_rd_row(o_rd_row),
        .o_rd_col(o_rd_col), .o_wr_ack(o_wr_ack), .o_err(o_err), .o_err_code(o_err_code),
        .o_open_cnt(o_open_cnt)
    );

    // model: absolute cycle stamps for readiness and read returns, no notion of FSM states
    typedef struct {int due; logic [26:0] d;} rd_t;
    rd_t         rq[$];
    int          cyc = 0, ready_at = 0, m_cnt = 0;
    bit          m_open [32];
    logic [15:0] m_row [32];
    bit          half = 0;
    logic [2:0]  hop = '0;
    logic [4:0]  hidx = '0;
    logic [15:0] haddr = '0;
    bit          e_ready = 1, e_rdv = 0, e_wr = 0, e_err = 0;
    logic [26:0] e_rd = '0;
    logic [2:0]  e_code = '0;

    task automatic tick(input logic v, input logic [2:0] o, input logic [2:0] b, input logic [1:0] a, input logic [15:0] ad);
        bit hs;
        logic [4:0] ix;
        rd_t r;
        valid = v; op = o; bg = b; ba = a; addr = ad;
        hs = v && rst_n && cyc >= ready_at;
        ix = {b, a};
        @(posedge clk);
        cyc++;
        e_wr = 0;
        e_err = 0;
        if (!rst_n) begin
            foreach (m_open[i]) m_open[i] = 0;
            m_cnt = 0; half = 0; rq.delete(); ready_at = cyc; e_code = 0;
        end else if (hs && o != 3'd0) begin
            if (!half) begin
                if (o == 3'd7) begin
                    if (m_open[ix]) begin m_open[ix] = 0; m_cnt--; end
                    ready_at = cyc + T_RP;
                end else if (o inside {3'd1, 3'd3, 3'd5}) begin
                    half = 1; hop = o; hidx = ix; haddr = ad;
                end else begin
                    e_err = 1; e_code = 3'd1;
                end
            end else begin
                half = 0;
                if (o inside {3'd1, 3'd3, 3'd5, 3'd7}) begin e_err = 1; e_code = 3'd1; end
                else if (o != hop + 3'd1 || ix != hidx) begin e_err = 1; e_code = 3'd2; end
                else if (o == 3'd2) begin
                    if (m_open[hidx]) begin e_err = 1; e_code = 3'd3; end
                    else begin m_open[hidx] = 1; m_row[hidx] = haddr; m_cnt++; ready_at = cyc + T_RCD; end
                end else if (!m_open[hidx]) begin e_err = 1; e_code = 3'd4; end
                else if (o == 3'd4) begin
                    r.due = cyc + RD_LAT - 1;
                    r.d = {hidx, m_row[hidx], haddr[5:0]};
                    rq.push_back(r);
                end else e_wr = 1;
            end
        end
        e_rdv = 0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            e_rdv = 1; e_rd = rq[0].d; rq.delete(0);
        end
        e_ready = cyc >= ready_at;
        #1;
    endtask

    task automatic nop();
        tick(0, 3'd0, 3'd0, 2'd0, 16'd0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 0;
        repeat (n) nop();
        rst_n = 1;
    endtask

    task automatic wait_ready();
        while (cyc < ready_at) nop();
    endtask

    task automatic test_reset();
        do_reset(2);
        tests++; if (o_cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0h expected 1", o_cmd_ready); end
        tests++; if (o_rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %0h expected 0", o_rd_valid); end
        tests++; if (o_wr_ack !== 1'b0) begin fails++; $display("FAIL reset_wr_ack: got %0h expected 0", o_wr_ack); end
        tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %0h expected 0", o_err); end
        tests++; if (o_err_code !== 3'd0) begin fails++; $display("FAIL reset_err_code: got %0h expected 0", o_err_code); end
        tests++; if (o_open_cnt !== 6'd0) begin fails++; $display("FAIL reset_open_cnt: got %0d expected 0", o_open_cnt); end
        tests++; if ({o_rd_bg, o_rd_ba, o_rd_row, o_rd_col} !== 27'd0) begin
            fails++; $display("FAIL reset_rd_fields: got %0h expected 0", {o_rd_bg, o_rd_ba, o_rd_row, o_rd_col});
        end
    endtask

    task automatic test_act_rd();
        int n;
        tick(1, 3'd1, 3'd2, 2'd1, 16'h1234);
        tick(1, 3'd2, 3'd2, 2'd1, 16'h0);
        n = 0;
        while (!o_cmd_ready && n < 20) begin n++; nop(); end
        tests++; if (n !== 3) begin fails++; $display("FAIL act_ready_low_cycles: got %0d expected 3", n); end
        tests++; if (o_open_cnt !== 6'd1) begin fails++; $display("FAIL act_open_cnt: got %0d expected 1", o_open_cnt); end
        tick(1, 3'd3, 3'd2, 2'd1, 16'h0015);
        tick(1, 3'd4, 3'd2, 2'd1, 16'h0);
        n = 1;
        while (!o_rd_valid && n < 20) begin n++; nop(); end
        tests++; if (n !== 4) begin fails++; $display("FAIL rd_latency: got %0d expected 4", n); end
        tests++; if ({o_rd_bg, o_rd_ba, o_rd_row, o_rd_col} !== {3'd2, 2'd1, 16'h1234, 6'h15}) begin
            fails++; $display("FAIL rd_fields: got %0h expected %0h", {o_rd_bg, o_rd_ba, o_rd_row, o_rd_col}, {3'd2, 2'd1, 16'h1234, 6'h15});
        end
        nop();
        tests++; if (o_rd_valid !== 1'b0) begin fails++; $display("FAIL rd_valid_width: got %0h expected 0", o_rd_valid); end
    endtask

    task automatic test_rd_closed();
        bit seen;
        tick(1, 3'd3, 3'd0, 2'd0, 16'h5);
        tick(1, 3'd4, 3'd0, 2'd0, 16'h0);
        tests++; if ({o_err, o_err_code} !== {1'b1, 3'd4}) begin fails++; $display("FAIL rd_closed_err: got %0h expected %0h", {o_err, o_err_code}, {1'b1, 3'd4}); end
        seen = 0;
        repeat (8) begin nop(); seen |= o_rd_valid; end
        tests++; if ({seen, o_err, o_err_code} !== {1'b0, 1'b0, 3'd4}) begin
            fails++; $display("FAIL rd_closed_after: got %0h expected %0h", {seen, o_err, o_err_code}, {1'b0, 1'b0, 3'd4});
        end
    endtask

    task automatic test_mismatch();
        tick(1, 3'd1, 3'd1, 2'd0, 16'h77);
        tick(1, 3'd2, 3'd3, 2'd0, 16'h0);
        tests++; if ({o_err, o_err_code} !== {1'b1, 3'd2}) begin fails++; $display("FAIL mismatch_err: got %0h expected %0h", {o_err, o_err_code}, {1'b1, 3'd2}); end
        tests++; if (o_open_cnt !== 6'd1) begin fails++; $display("FAIL mismatch_open_cnt: got %0d expected 1", o_open_cnt); end
        tick(1, 3'd2, 3'd1, 2'd0, 16'h0);
        tests++; if ({o_err, o_err_code} !== {1'b1, 3'd1}) begin fails++; $display("FAIL mismatch_back_idle: got %0h expected %0h", {o_err, o_err_code}, {1'b1, 3'd1}); end
    endtask

    task automatic test_bank_open_pre();
        int n;
        tick(1, 3'd1, 3'd2, 2'd1, 16'h5555);
        tick(1, 3'd2, 3'd2, 2'd1, 16'h0);
        tests++; if ({o_err, o_err_code, o_cmd_ready} !== {1'b1, 3'd3, 1'b1}) begin
            fails++; $display("FAIL bank_open_err: got %0h expected %0h", {o_err, o_err_code, o_cmd_ready}, {1'b1, 3'd3, 1'b1});
        end
        tick(1, 3'd7, 3'd2, 2'd1, 16'h0);
        n = 0;
        while (!o_cmd_ready && n < 20) begin n++; nop(); end
        tests++; if (n !== 2) begin fails++; $display("FAIL pre_ready_low_cycles: got %0d expected 2", n); end
        tests++; if (o_open_cnt !== 6'd0) begin fails++; $display("FAIL pre_open_cnt: got %0d expected 0", o_open_cnt); end
        tick(1, 3'd7, 3'd7, 2'd3, 16'h0);
        tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL pre_closed_err: got %0h expected 0", o_err); end
        n = 0;
        while (!o_cmd_ready && n < 20) begin n++; nop(); end
        tests++; if ({n, o_open_cnt} !== {32'd2, 6'd0}) begin fails++; $display("FAIL pre_closed_wait: got %0h expected %0h", {n, o_open_cnt}, {32'd2, 6'd0}); end
    endtask

    task automatic test_reset_inflight();
        bit seen;
        tick(1, 3'd1, 3'd4, 2'd2, 16'hbeef);
        tick(1, 3'd2, 3'd4, 2'd2, 16'h0);
        wait_ready();
        tick(1, 3'd3, 3'd4, 2'd2, 16'h3);
        tick(1, 3'd4, 3'd4, 2'd2, 16'h0);
        nop();
        do_reset(2);
        seen = 0;
        repeat (8) begin nop(); seen |= o_rd_valid; end
        tests++; if ({seen, o_open_cnt, o_cmd_ready} !== {1'b0, 6'd0, 1'b1}) begin
            fails++; $display("FAIL reset_inflight: got %0h expected %0h", {seen, o_open_cnt, o_cmd_ready}, {1'b0, 6'd0, 1'b1});
        end
        tick(1, 3'd1, 3'd1, 2'd1, 16'h9);
        do_reset(1);
        tick(1, 3'd2, 3'd1, 2'd1, 16'h0);
        tests++; if ({o_err, o_err_code, o_open_cnt} !== {1'b1, 3'd1, 6'd0}) begin
            fails++; $display("FAIL reset_mid_half: got %0h expected %0h", {o_err, o_err_code, o_open_cnt}, {1'b1, 3'd1, 6'd0});
        end
    endtask

    task automatic test_wr();
        tick(1, 3'd6, 3'd5, 2'd2, 16'h0);
        tests++; if ({o_err, o_err_code, o_wr_ack} !== {1'b1, 3'd1, 1'b0}) begin
            fails++; $display("FAIL wr_seq_err: got %0h expected %0h", {o_err, o_err_code, o_wr_ack}, {1'b1, 3'd1, 1'b0});
        end
        tick(1, 3'd1, 3'd5, 2'd2, 16'h4321);
        tick(1, 3'd2, 3'd5, 2'd2, 16'h0);
        wait_ready();
        tick(1, 3'd5, 3'd5, 2'd2, 16'h9);
        nop();
        tick(1, 3'd6, 3'd5, 2'd2, 16'h0);
        tests++; if ({o_wr_ack, o_err} !== 2'b10) begin fails++; $display("FAIL wr_ack: got %0h expected 2", {o_wr_ack, o_err}); end
        nop();
        tests++; if (o_wr_ack !== 1'b0) begin fails++; $display("FAIL wr_ack_width: got %0h expected 0", o_wr_ack); end
    endtask

    task automatic test_random();
        logic [2:0] o, b;
        logic [1:0] a;
        for (int i = 0; i < 3000; i++) begin
            rst_n = $urandom_range(0, 299) != 0;
            if (half && $urandom_range(0, 3) != 0) begin
                o = hop + 3'd1; {b, a} = hidx;
            end else begin
                o = 3'($urandom_range(0, 7)); b = 3'($urandom_range(0, 1)); a = 2'($urandom_range(0, 3));
            end
            tick($urandom_range(0, 9) < 8, o, b, a, 16'($urandom));
            tests++; if (o_cmd_ready !== e_ready) begin fails++; $display("FAIL rnd_ready cyc %0d: got %0h expected %0h", cyc, o_cmd_ready, e_ready); end
            tests++; if (o_rd_valid !== e_rdv) begin fails++; $display("FAIL rnd_rd_valid cyc %0d: got %0h expected %0h", cyc, o_rd_valid, e_rdv); end
            if (e_rdv) begin
                tests++; if ({o_rd_bg, o_rd_ba, o_rd_row, o_rd_col} !== e_rd) begin
                    fails++; $display("FAIL rnd_rd_fields cyc %0d: got %0h expected %0h", cyc, {o_rd_bg, o_rd_ba, o_rd_row, o_rd_col}, e_rd);
                end
            end
            tests++; if (o_wr_ack !== e_wr) begin fails++; $display("FAIL rnd_wr_ack cyc %0d: got %0h expected %0h", cyc, o_wr_ack, e_wr); end
            tests++; if (o_err !== e_err) begin fails++; $display("FAIL rnd_err cyc %0d: got %0h expected %0h", cyc, o_err, e_err); end
            tests++; if (o_err_code !== e_code) begin fails++; $display("FAIL rnd_err_code cyc %0d: got %0h expected %0h", cyc, o_err_code, e_code); end
            tests++; if (o_open_cnt !== 6'(m_cnt)) begin fails++; $display("FAIL rnd_open_cnt cyc %0d: got %0d expected %0d", cyc, o_open_cnt, m_cnt); end
        end
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_act_rd();
        test_rd_closed();
        test_mismatch();
        test_bank_open_pre();
        test_reset_inflight();
        test_wr();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
